// File: rtl/boot_pkg.sv
// Shared types and constants for the bootloader word assembler.
package boot_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_WRITE   = 1'b1
    } boot_state_e;

endpackage

// File: rtl/boot_word_assembler.sv
// Packs UART RX bytes little-endian into 32-bit words and writes them to boot RAM.
// Optional running checksum of accepted words: define BOOT_WORD_CHECKSUM_EN.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_COLLECT | accepting bytes into lanes; idle timer runs on a partial word
// ST_WRITE   | word presented on the write port; one byte may wait in skid
module boot_word_assembler
    import boot_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter int BASE_ADDR      = 0,
    parameter int TIMEOUT_CYCLES = 2000
) (
    input  logic              hwclk,
    input  logic              reset,
    input  logic              rx_dv,
    input  logic [7:0]        rx_byte,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic [ADDR_W:0]   word_count,
    output logic              overrun,
    output logic              timeout_pulse
`ifdef BOOT_WORD_CHECKSUM_EN
    ,
    output logic [WORD_W-1:0] checksum
`endif
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);
    localparam logic [ADDR_W:0]  WC_MAX   = {1'b1, {ADDR_W{1'b0}}};

    boot_state_e      state;
    logic [IDX_W-1:0] idx;
    logic             skid_valid;
    logic [7:0]       skid_byte;
    logic [CNT_W-1:0] idle_cnt;
    logic             idle_run;
    logic             handshake;

    assign wr_valid  = (state == ST_WRITE);
    assign handshake = (state == ST_WRITE) && wr_ready;
    assign idle_run  = (state == ST_COLLECT) && (idx != '0);

    // Idle timer is a down-counter reloaded by every byte; expiry at zero.
    always_ff @(posedge hwclk) begin
        if (reset) begin
            idle_cnt <= CNT_LOAD;
        end else if (rx_dv) begin
            idle_cnt <= CNT_LOAD;
        end else if (idle_run) begin
            if (idle_cnt == '0) idle_cnt <= CNT_LOAD;
            else                idle_cnt <= idle_cnt - 1'b1;
        end
    end

    always_ff @(posedge hwclk) begin
        if (reset) begin
            state         <= ST_COLLECT;
            idx           <= '0;
            skid_valid    <= 1'b0;
            skid_byte     <= '0;
            wr_addr       <= ADDR_W'(BASE_ADDR);
            wr_data       <= '0;
            word_count    <= '0;
            overrun       <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= 1'b0;
            case (state)
                ST_COLLECT: begin
                    if (rx_dv) begin
                        wr_data[{idx, 3'b000} +: 8] <= rx_byte;
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= ST_WRITE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else if (idle_run && idle_cnt == '0) begin
                        wr_data       <= '0;
                        idx           <= '0;
                        timeout_pulse <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (handshake) begin
                        state      <= ST_COLLECT;
                        wr_addr    <= wr_addr + 1'b1;
                        skid_valid <= 1'b0;
                        if (word_count != WC_MAX) word_count <= word_count + 1'b1;
                        // Skid byte takes lane 0; a byte arriving now follows it.
                        if (skid_valid) begin
                            wr_data[7:0] <= skid_byte;
                            if (rx_dv) begin
                                wr_data[15:8] <= rx_byte;
                                idx           <= IDX_W'(2);
                            end else begin
                                idx <= IDX_W'(1);
                            end
                        end else if (rx_dv) begin
                            wr_data[7:0] <= rx_byte;
                            idx          <= IDX_W'(1);
                        end else begin
                            idx <= '0;
                        end
                    end else if (rx_dv) begin
                        if (!skid_valid) begin
                            skid_valid <= 1'b1;
                            skid_byte  <= rx_byte;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                end
                default: state <= ST_COLLECT;
            endcase
        end
    end

`ifdef BOOT_WORD_CHECKSUM_EN
    always_ff @(posedge hwclk) begin
        if (reset)          checksum <= '0;
        else if (handshake) checksum <= checksum + wr_data;
    end
`endif

endmodule

// File: doc/boot_word_assembler.md
# boot_word_assembler

Downstream consumer of the UART receiver in the bootloader: takes the byte stream delivered by the RX data-valid strobe and packs every four bytes, little-endian, into a 32-bit word. It writes each word to program memory at consecutive word addresses through a valid/ready write port. It also recovers from broken transfers with an inter-byte timeout and flags bytes lost to memory backpressure. It sits between the UART RX and the boot RAM inside `top`.

## Interface
- `ADDR_W`, 8: word-address width; the memory holds 2^ADDR_W words.
- `BASE_ADDR`, 0: word address of the first word written after reset.
- `TIMEOUT_CYCLES`, 2000: idle cycles after which a partial word is discarded. Must be at least 1; the default exceeds one byte time at 12 MHz / 115200.

- `hwclk` in 1: the single clock.
- `reset` in 1: reset is synchronous and active-high.
- `rx_dv` in 1: one-cycle strobe; a byte is valid on `rx_byte`.
- `rx_byte` in 8: received byte.
- `wr_valid` out 1: a word is presented to memory.
- `wr_ready` in 1: memory accepts the word.
- `wr_addr` out ADDR_W: target word address.
- `wr_data` out 32: assembled word.
- `word_count` out ADDR_W+1: accepted words; saturates at 2^ADDR_W.
- `overrun` out 1: sticky; a byte was dropped.
- `timeout_pulse` out 1: one-cycle pulse when a partial word is discarded.
- `checksum` out 32: present only with `BOOT_WORD_CHECKSUM_EN`.

## Operation
- States:
  - COLLECT: accepts bytes.
  - WRITE: holds `wr_valid` until the handshake completes.
- Byte index `idx` (0..3) selects the lane; byte k goes to `wr_data[8k+7:8k]`.
- COLLECT with `rx_dv` and `idx`<3: store the byte in its lane, `idx`+1.
- COLLECT with `rx_dv` and `idx`==3: store the byte, `idx`=0, go to WRITE.
- WRITE: `wr_valid`=1; `wr_addr` and `wr_data` are stable until the handshake.
  - Handshake is the cycle with `wr_valid && wr_ready`.
  - On handshake: go to COLLECT, advance the address by 1, increment `word_count`.
  - The address wraps modulo 2^ADDR_W. `word_count` stops at 2^ADDR_W.
- One-byte skid register, used only while in WRITE:
  - The first `rx_dv` goes into the skid.
  - Any further `rx_dv` is dropped and sets `overrun`=1.
  - On the handshake cycle:
    - A held skid byte becomes lane 0 of the next word (`idx`=1).
    - An `rx_dv` in that same cycle lands in the next free lane: lane 1 if the skid is held, else lane 0.
- Timeout:
  - An idle counter clears on every `rx_dv` and counts only in COLLECT with `idx`≠0.
  - When it reaches TIMEOUT_CYCLES-1 with no byte: clear the lanes, set `idx`=0, pulse `timeout_pulse`.
  - The address and `word_count` do not change on timeout.
  - If a byte arrives in the expiry cycle, the byte wins and there is no timeout.
- Reset mid-operation: the partial word, the skid and a pending write are all discarded.
- Reset values:
  - `wr_valid`=0, `wr_addr`=BASE_ADDR, `wr_data`=0.
  - `word_count`=0, `overrun`=0, `timeout_pulse`=0, `checksum`=0.
  - State COLLECT, `idx`=0.

## Timing
- Fourth-byte `rx_dv` in cycle N: `wr_valid`=1 from N+1.
- Handshake in cycle M:
  - `wr_valid`=0 and the new `wr_addr` are visible from M+1.
  - `word_count` and `checksum` update at M+1.
- `wr_ready` may be high before `wr_valid`. Minimum write latency is one cycle.
- All outputs are registered; there is no combinational path from `rx_dv`/`wr_ready` to any output.

## Configuration
- `BOOT_WORD_CHECKSUM_EN` defined:
  - `checksum` port exists.
  - It holds the 32-bit wrapping sum of all accepted words, updated at the handshake.
  - It clears on reset.
- `BOOT_WORD_CHECKSUM_EN` undefined: no port and no adder; all other behaviour is identical.

## Structure
- Package `boot_pkg`:
  - State enum (COLLECT, WRITE).
  - `WORD_W`=32, `BYTES_PER_WORD`=4.
- Single module with no sub-modules. The timeout counter and skid are too small to split out.

## Test plan
- Bytes 00 01 02 03, then 04 05 06 07, `wr_ready`=1:
  - Writes 0x03020100 @0 and 0x07060504 @1.
  - `word_count`=2.
  - With the macro, `checksum`=0x0A080604.
- Bytes 11 22, then TIMEOUT_CYCLES idle cycles, then AA BB CC DD:
  - One `timeout_pulse`.
  - Single write of 0xDDCCBBAA @0.
- `wr_ready`=0 after bytes 00..03, then bytes 44 and 55:
  - `overrun`=1; 55 is dropped.
  - Raise `wr_ready`: 0x03020100 @0 is written.
  - Then bytes 66 77 88 produce 0x88776644 @1.
- `ADDR_W`=2, 5 words of bytes 01..14:
  - Fifth word 0x14131211 is written @0.
  - `word_count`=4 (saturated).
- Bytes 01 02 03, then `reset` pulse, then 0A 0B 0C 0D:
  - No write before reset.
  - 0x0D0C0B0A @BASE_ADDR.
  - `overrun`=0.
- `rx_dv` with byte EE in the handshake cycle, skid empty: EE lands in lane 0 of the next word (`idx`=1).
